multdiv_issue_ctrl: RTL and testbench

//  Execute-stage initiator for the iterative multdiv unit. Captures a MULT/DIV from the pipeline,

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/md_timeout_ctr.sv | 35 +++
 rtl/multdiv_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg
// Shared definitions for the multdiv issue controller: FSM state encoding
// and default values for widths, timeout, exception register and codes.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_REG_W       = 5;
    localparam int DEF_TIMEOUT     = 64;
    localparam int DEF_RSTATUS_REG = 30;
    localparam int DEF_EXC_MULT    = 4;
    localparam int DEF_EXC_DIV     = 5;

endpackage

// File: rtl/md_timeout_ctr.sv
// md_timeout_ctr
// Counts cycles an operation has spent waiting on the multdiv unit.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   clear         force the count back to zero (start of an operation)
//   enable        advance the count by one this cycle
//   terminal      high while the current enabled cycle is the TIMEOUT-th
//                 cycle after the start pulse
module md_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // The count holds the number of waiting cycles already completed, so the
    // flag fires one below TIMEOUT: that cycle is the TIMEOUT-th one.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl
// Execute-stage initiator for the iterative multdiv unit. Captures a MULT or
// DIV, holds its operands, sends a one-cycle start pulse, stalls the pipeline
// until the unit reports ready (or times out) and then presents one writeback.
// Ports:
//   clock, reset                    system clock, synchronous active-high reset
//   ex_valid/ex_is_mult/ex_is_div   execute-stage instruction and its kind
//   ex_flush                        squash of the instruction / in-flight op
//   ex_opA, ex_opB, ex_rd           operands and destination register
//   data_operandA/B                 held operands to the multdiv unit
//   ctrl_MULT, ctrl_DIV             one-cycle start pulses
//   data_result/exception/resultRDY multdiv response
//   stall                           freeze fetch/decode/execute
//   wb_valid, wb_rd, wb_data        one-cycle writeback
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int REG_W       = DEF_REG_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int RSTATUS_REG = DEF_RSTATUS_REG,
    parameter int EXC_MULT    = DEF_EXC_MULT,
    parameter int EXC_DIV     = DEF_EXC_DIV
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_mult,
    input  logic             ex_is_div,
    input  logic             ex_flush,
    input  logic [WIDTH-1:0] ex_opA,
    input  logic [WIDTH-1:0] ex_opB,
    input  logic [REG_W-1:0] ex_rd,
    output logic [WIDTH-1:0] data_operandA,
    output logic [WIDTH-1:0] data_operandB,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_result,
    input  logic             data_exception,
    input  logic             data_resultRDY,
    output logic             stall,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic [WIDTH-1:0] wb_data
);

    md_state_t        state;
    md_state_t        next_state;
    logic             issue;
    logic             issue_div;
    logic             timeout_hit;
    logic             finish_op;
    logic             op_exc;
    logic [REG_W-1:0] rd_q;
    logic             is_div_q;

    assign issue = ex_valid & (ex_is_mult | ex_is_div) & ~ex_flush;

    // An instruction flagged as both MULT and DIV is run as a multiply.
    assign issue_div = ex_is_div & ~ex_is_mult;

    // A flush wins over a completion arriving in the same BUSY cycle.
    assign finish_op = (state == ST_BUSY) && !ex_flush && (data_resultRDY || timeout_hit);

    // A timeout without ready is reported as an exception of the op's kind.
    assign op_exc = data_resultRDY ? data_exception : 1'b1;

    assign stall = ((state == ST_IDLE) && issue) || (state == ST_START) || (state == ST_BUSY);

    md_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clock    (clock),
        .reset    (reset),
        .clear    (state == ST_START),
        .enable   (state == ST_BUSY),
        .terminal (timeout_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // START ignores data_resultRDY so a ready left over from an earlier
    // (possibly flushed) operation can never complete the new one.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                next_state = ex_flush ? ST_IDLE : ST_BUSY;
            end
            ST_BUSY: begin
                if (ex_flush) begin
                    next_state = ST_IDLE;
                end else if (data_resultRDY || timeout_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Pulses and writeback fields are set on the edge entering START/DONE
    // and fall back to zero otherwise, so each lasts exactly one cycle.
    // Operands and the captured destination only change on a new issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_operandA <= '0;
            data_operandB <= '0;
            rd_q          <= '0;
            is_div_q      <= 1'b0;
            ctrl_MULT     <= 1'b0;
            ctrl_DIV      <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
        end else begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            if ((state == ST_IDLE) && issue) begin
                data_operandA <= ex_opA;
                data_operandB <= ex_opB;
                rd_q          <= ex_rd;
                is_div_q      <= issue_div;
                ctrl_MULT     <= ~issue_div;
                ctrl_DIV      <= issue_div;
            end
            if (finish_op) begin
                if (op_exc) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= REG_W'(RSTATUS_REG);
                    wb_data  <= is_div_q ? WIDTH'(EXC_DIV) : WIDTH'(EXC_MULT);
                end else if (rd_q != '0) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= data_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl
// Directed bench for multdiv_issue_ctrl. The bench plays the multdiv unit by
// hand, raising data_resultRDY a chosen number of cycles after the start pulse.
module tb_multdiv_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_is_mult;
    logic        ex_is_div;
    logic        ex_flush;
    logic [31:0] ex_opA;
    logic [31:0] ex_opB;
    logic [4:0]  ex_rd;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    multdiv_issue_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_is_mult     (ex_is_mult),
        .ex_is_div      (ex_is_div),
        .ex_flush       (ex_flush),
        .ex_opA         (ex_opA),
        .ex_opB         (ex_opB),
        .ex_rd          (ex_rd),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one op in the current IDLE cycle and answers with ready n cycles
    // after the start pulse. stale_rdy holds ready high through issue and START.
    task automatic applyStimulus(input logic is_m, input logic is_d,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                                 input int n, input logic [31:0] res, input logic exc,
                                 input logic stale_rdy, input logic exp_mult,
                                 input logic exp_valid, input logic [4:0] exp_rd,
                                 input logic [31:0] exp_data);
        int bad;
        ex_valid = 1'b1; ex_is_mult = is_m; ex_is_div = is_d;
        ex_opA = a; ex_opB = b; ex_rd = rd;
        data_resultRDY = stale_rdy;
        data_result = 32'hBAD0_BAD0;
        #1;
        checkOutput("stall_on_issue", stall, 1);
        tick();
        ex_valid = 1'b0; ex_is_mult = 1'b0; ex_is_div = 1'b0;
        ex_opA = 32'h5555_5555; ex_opB = 32'hAAAA_AAAA; ex_rd = 5'd31;
        checkOutput("ctrl_MULT_pulse", ctrl_MULT, exp_mult);
        checkOutput("ctrl_DIV_pulse", ctrl_DIV, !exp_mult);
        checkOutput("operandA", data_operandA, a);
        checkOutput("operandB", data_operandB, b);
        bad = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            data_resultRDY = 1'b0;
            if (ctrl_MULT || ctrl_DIV || wb_valid || !stall) bad++;
            if (data_operandA !== a || data_operandB !== b) bad++;
        end
        checkOutput("busy_wait", bad, 0);
        data_resultRDY = 1'b1; data_result = res; data_exception = exc;
        tick();
        data_resultRDY = 1'b0; data_exception = 1'b0;
        checkOutput("wb_valid", wb_valid, exp_valid);
        checkOutput("wb_rd", wb_rd, exp_rd);
        checkOutput("wb_data", wb_data, exp_data);
        checkOutput("stall_done", stall, 0);
        tick();
        checkOutput("wb_valid_once", wb_valid, 0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; ex_valid = 1'b0; ex_is_mult = 1'b0; ex_is_div = 1'b0; ex_flush = 1'b0;
        ex_opA = '0; ex_opB = '0; ex_rd = '0;
        data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        checkOutput("rst_wb", {wb_valid, wb_rd}, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_operands", data_operandA | data_operandB, 0);

        // MULT 6*7 -> 42 in rd 3
        applyStimulus(1, 0, 32'd6, 32'd7, 5'd3, 4, 32'd42, 0, 0, 1, 1, 5'd3, 32'd42);
        // DIV -20/6 -> -3 in rd 8
        applyStimulus(0, 1, 32'hFFFF_FFEC, 32'd6, 5'd8, 10, 32'hFFFF_FFFD, 0, 0, 0, 1, 5'd8, 32'hFFFF_FFFD);
        // DIV 5/0 -> exception code 5 into rstatus
        applyStimulus(0, 1, 32'd5, 32'd0, 5'd9, 7, 32'hDEAD_BEEF, 1, 0, 0, 1, 5'd30, 32'd5);
        // Stale ready held through START, real ready at 33 cycles
        applyStimulus(1, 0, 32'd100, 32'd3, 5'd12, 33, 32'd300, 0, 1, 1, 1, 5'd12, 32'd300);
        // rd 0 without exception: no writeback
        applyStimulus(1, 0, 32'd2, 32'd2, 5'd0, 2, 32'd4, 0, 0, 1, 0, 5'd0, 32'd0);
        // Both kind bits: runs as MULT, timeout-free
        applyStimulus(1, 1, 32'd9, 32'd9, 5'd1, 1, 32'd81, 0, 0, 1, 1, 5'd1, 32'd81);

        // Flush in the issue cycle blocks the issue
        ex_valid = 1'b1; ex_is_mult = 1'b1; ex_flush = 1'b1;
        #1;
        checkOutput("flush_issue_stall", stall, 0);
        tick();
        ex_valid = 1'b0; ex_is_mult = 1'b0; ex_flush = 1'b0;
        checkOutput("flush_issue_pulse", ctrl_MULT, 0);

        // Flush 10 cycles into BUSY
        ex_valid = 1'b1; ex_is_mult = 1'b1; ex_opA = 32'd11; ex_opB = 32'd12; ex_rd = 5'd7;
        tick();
        ex_valid = 1'b0; ex_is_mult = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0;
        checkOutput("flush_stall", stall, 0);
        cyc = 0;
        for (int k = 0; k < 5; k++) begin
            if (wb_valid) cyc++;
            tick();
        end
        checkOutput("flush_no_wb", cyc, 0);
        applyStimulus(1, 0, 32'd2, 32'd3, 5'd4, 3, 32'd6, 0, 0, 1, 1, 5'd4, 32'd6);

        // Ready never arrives: forced MULT exception 65 cycles after the pulse
        ex_valid = 1'b1; ex_is_mult = 1'b1; ex_opA = 32'd1; ex_opB = 32'd1; ex_rd = 5'd5;
        tick();
        ex_valid = 1'b0; ex_is_mult = 1'b0;
        cyc = 0;
        while (!wb_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        checkOutput("timeout_cycles", cyc, 65);
        checkOutput("timeout_rd", wb_rd, 5'd30);
        checkOutput("timeout_data", wb_data, 32'd4);
        tick();

        // Reset in the middle of BUSY
        ex_valid = 1'b1; ex_is_div = 1'b1; ex_opA = 32'd77; ex_opB = 32'd7; ex_rd = 5'd6;
        tick();
        ex_valid = 1'b0; ex_is_div = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_stall", stall, 0);
        checkOutput("midrst_ctrl_wb", {ctrl_MULT, ctrl_DIV, wb_valid, wb_rd}, 0);
        checkOutput("midrst_operandA", data_operandA, 0);
        checkOutput("midrst_wb_data", wb_data, 0);
        data_resultRDY = 1'b1; data_result = 32'd11;
        tick();
        data_resultRDY = 1'b0;
        checkOutput("midrst_no_wb", wb_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
